// File: rtl/ex_mem_pkg.sv
// Shared definitions for the EX/MEM pipeline register: stall bit positions,
// write-enable levels, load/store opcodes and accumulate step encodings.
package ex_mem_pkg;

  localparam int DATA_W_DEF     = 32;
  localparam int REG_ADDR_W_DEF = 5;
  localparam int ALUOP_W_DEF    = 8;
  localparam int STALL_W        = 6;

  localparam int STALL_EX  = 3;
  localparam int STALL_MEM = 4;

  localparam logic [31:0] ZERO_WORD     = 32'h0000_0000;
  localparam logic        WRITE_ENABLE  = 1'b1;
  localparam logic        WRITE_DISABLE = 1'b0;

  localparam logic [7:0] EXE_NOP_OP  = 8'b0000_0000;
  localparam logic [7:0] EXE_LB_OP   = 8'b1110_0000;
  localparam logic [7:0] EXE_LH_OP   = 8'b1110_0001;
  localparam logic [7:0] EXE_LW_OP   = 8'b1110_0011;
  localparam logic [7:0] EXE_LBU_OP  = 8'b1110_0100;
  localparam logic [7:0] EXE_LHU_OP  = 8'b1110_0101;
  localparam logic [7:0] EXE_SB_OP   = 8'b1110_1000;
  localparam logic [7:0] EXE_SH_OP   = 8'b1110_1001;
  localparam logic [7:0] EXE_SW_OP   = 8'b1110_1011;
  localparam logic [7:0] EXE_MADD_OP = 8'b1010_0110;
  localparam logic [7:0] EXE_MSUB_OP = 8'b1010_1000;

  // Multi-cycle accumulate progress handed back to EX across a bubble.
  localparam logic [1:0] CNT_IDLE  = 2'b00;
  localparam logic [1:0] CNT_STEP1 = 2'b01;
  localparam logic [1:0] CNT_RSVD  = 2'b10;

endpackage

// File: rtl/ex_mem.sv
// EX/MEM pipeline register. Carries GPR/HI-LO write-back and load/store fields
// one cycle toward MEM, and parks the accumulate partial result during a bubble.
module ex_mem
  import ex_mem_pkg::*;
#(
  parameter int DATA_W     = DATA_W_DEF,
  parameter int REG_ADDR_W = REG_ADDR_W_DEF,
  parameter int ALUOP_W    = ALUOP_W_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [STALL_W-1:0]    stall,
  input  logic                  flush,

  input  logic [REG_ADDR_W-1:0] ex_wd,
  input  logic                  ex_wreg,
  input  logic [DATA_W-1:0]     ex_wdata,
  input  logic [DATA_W-1:0]     ex_hi,
  input  logic [DATA_W-1:0]     ex_lo,
  input  logic                  ex_whilo,
  input  logic [ALUOP_W-1:0]    ex_aluop,
  input  logic [DATA_W-1:0]     ex_mem_addr,
  input  logic [DATA_W-1:0]     ex_reg2,
  input  logic [2*DATA_W-1:0]   hilo_i,
  input  logic [1:0]            cnt_i,

  output logic [REG_ADDR_W-1:0] mem_wd,
  output logic                  mem_wreg,
  output logic [DATA_W-1:0]     mem_wdata,
  output logic [DATA_W-1:0]     mem_hi,
  output logic [DATA_W-1:0]     mem_lo,
  output logic                  mem_whilo,
  output logic [ALUOP_W-1:0]    mem_aluop,
  output logic [DATA_W-1:0]     mem_mem_addr,
  output logic [DATA_W-1:0]     mem_reg2,
  output logic                  mem_valid,
  output logic [2*DATA_W-1:0]   hilo_o,
  output logic [1:0]            cnt_o
);

  // Only the EX and MEM stall bits matter to this stage.
  logic unused_stall_bits;
  assign unused_stall_bits = ^{stall[5], stall[2:0]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_wd       <= '0;
      mem_wreg     <= WRITE_DISABLE;
      mem_wdata    <= '0;
      mem_hi       <= '0;
      mem_lo       <= '0;
      mem_whilo    <= WRITE_DISABLE;
      mem_aluop    <= '0;
      mem_mem_addr <= '0;
      mem_reg2     <= '0;
      mem_valid    <= 1'b0;
      hilo_o       <= '0;
      cnt_o        <= CNT_IDLE;
    end else if (flush) begin
      mem_wd       <= '0;
      mem_wreg     <= WRITE_DISABLE;
      mem_wdata    <= '0;
      mem_hi       <= '0;
      mem_lo       <= '0;
      mem_whilo    <= WRITE_DISABLE;
      mem_aluop    <= '0;
      mem_mem_addr <= '0;
      mem_reg2     <= '0;
      mem_valid    <= 1'b0;
      hilo_o       <= '0;
      cnt_o        <= CNT_IDLE;
    end else if (stall[STALL_MEM]) begin
      // MEM stalled: hold everything, whatever EX is doing.
      mem_wd       <= mem_wd;
      mem_wreg     <= mem_wreg;
      mem_wdata    <= mem_wdata;
      mem_hi       <= mem_hi;
      mem_lo       <= mem_lo;
      mem_whilo    <= mem_whilo;
      mem_aluop    <= mem_aluop;
      mem_mem_addr <= mem_mem_addr;
      mem_reg2     <= mem_reg2;
      mem_valid    <= mem_valid;
      hilo_o       <= hilo_o;
      cnt_o        <= cnt_o;
    end else if (stall[STALL_EX]) begin
      // EX stalled, MEM free: send a bubble and keep the accumulate state.
      mem_wd       <= '0;
      mem_wreg     <= WRITE_DISABLE;
      mem_wdata    <= '0;
      mem_hi       <= '0;
      mem_lo       <= '0;
      mem_whilo    <= WRITE_DISABLE;
      mem_aluop    <= '0;
      mem_mem_addr <= '0;
      mem_reg2     <= '0;
      mem_valid    <= 1'b0;
      hilo_o       <= hilo_i;
      cnt_o        <= cnt_i;
    end else begin
      mem_wd       <= ex_wd;
      mem_wreg     <= ex_wreg;
      mem_wdata    <= ex_wdata;
      mem_hi       <= ex_hi;
      mem_lo       <= ex_lo;
      mem_whilo    <= ex_whilo;
      mem_aluop    <= ex_aluop;
      mem_mem_addr <= ex_mem_addr;
      mem_reg2     <= ex_reg2;
      mem_valid    <= 1'b1;
      hilo_o       <= '0;
      cnt_o        <= CNT_IDLE;
    end
  end

endmodule
